// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the two-master SRAM-like bus arbiter.
//   id_t / ID_INST / ID_DATA : request owner tag stored in the ID FIFO
//   sram_req_t               : {wr, size, wstrb, addr, wdata} payload, muxed as one bus
//   grant_t                  : arbitration result
package sram_bus_arbiter_pkg;

  localparam int unsigned ADDR_WD  = 32;
  localparam int unsigned DATA_WD  = 32;
  localparam int unsigned SIZE_WD  = 2;
  localparam int unsigned WSTRB_WD = 4;

  typedef logic id_t;
  localparam id_t ID_INST = 1'b0;
  localparam id_t ID_DATA = 1'b1;

  typedef struct packed {
    logic                wr;
    logic [SIZE_WD-1:0]  size;
    logic [WSTRB_WD-1:0] wstrb;
    logic [ADDR_WD-1:0]  addr;
    logic [DATA_WD-1:0]  wdata;
  } sram_req_t;

  localparam int unsigned SRAM_REQ_WD = $bits(sram_req_t);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } grant_t;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Bundle of the instruction, data and bridge-facing SRAM-like bus signals.
//   slave  : arbiter view (master requests and bridge responses in)
//   master : environment view (the mirror image)
interface sram_bus_arbiter_if;
  import sram_bus_arbiter_pkg::*;

  logic                inst_req;
  logic                inst_wr;
  logic [SIZE_WD-1:0]  inst_size;
  logic [WSTRB_WD-1:0] inst_wstrb;
  logic [ADDR_WD-1:0]  inst_addr;
  logic [DATA_WD-1:0]  inst_wdata;
  logic                inst_addr_ok;
  logic                inst_data_ok;
  logic [DATA_WD-1:0]  inst_rdata;

  logic                data_req;
  logic                data_wr;
  logic [SIZE_WD-1:0]  data_size;
  logic [WSTRB_WD-1:0] data_wstrb;
  logic [ADDR_WD-1:0]  data_addr;
  logic [DATA_WD-1:0]  data_wdata;
  logic                data_addr_ok;
  logic                data_data_ok;
  logic [DATA_WD-1:0]  data_rdata;

  logic                mem_req;
  logic                mem_wr;
  logic [SIZE_WD-1:0]  mem_size;
  logic [WSTRB_WD-1:0] mem_wstrb;
  logic [ADDR_WD-1:0]  mem_addr;
  logic [DATA_WD-1:0]  mem_wdata;
  logic                mem_addr_ok;
  logic                mem_data_ok;
  logic [DATA_WD-1:0]  mem_rdata;

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
  );

endinterface

// File: rtl/sram_bus_arbiter_arb_id_fifo.sv
// In-order FIFO of 1-bit request owner IDs.
//   clk, resetn : clock, async active-low reset (empties the FIFO)
//   push, din   : enqueue din (caller guarantees !full)
//   pop         : dequeue head (caller guarantees !empty)
//   head        : oldest entry; full / empty status from the occupancy count
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-master (inst, data) to one-slave SRAM-like bus arbiter.
//   clk, resetn : clock, async active-low reset
//   bus         : inst/data master ports and the merged bridge port
//   arb_err     : sticky flag, data_ok returned with nothing outstanding
// Fixed priority data > inst with a starvation guard, a grant lock across
// stalled address phases, and an in-order ID FIFO steering data_ok.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned OST_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_bus_arbiter_if.slave     bus,
  output logic                  arb_err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  grant_t        grant;
  logic          lock_valid;
  id_t           lock_id;
  logic [SW-1:0] starve_cnt;
  logic          starved;
  logic          mem_req_c;
  logic          handshake;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  id_t           fifo_head;
  id_t           grant_id;
  sram_req_t     inst_pl;
  sram_req_t     data_pl;
  sram_req_t     mem_pl;

  assign starved = (starve_cnt == SW'(STARVE_LIMIT));

  // Grant selection; a full FIFO blocks everything, even with a same-cycle pop.
  always_comb begin
    grant = GNT_NONE;
    if (!fifo_full) begin
      if (lock_valid && (lock_id == ID_INST) && bus.inst_req) begin
        grant = GNT_INST;
      end else if (lock_valid && (lock_id == ID_DATA) && bus.data_req) begin
        grant = GNT_DATA;
      end else if (starved && bus.inst_req) begin
        grant = GNT_INST;
      end else if (bus.data_req) begin
        grant = GNT_DATA;
      end else if (bus.inst_req) begin
        grant = GNT_INST;
      end
    end
  end

  assign grant_id  = (grant == GNT_DATA) ? ID_DATA : ID_INST;
  assign mem_req_c = resetn && (grant != GNT_NONE);
  assign handshake = mem_req_c && bus.mem_addr_ok;

  // Request payload mux.
  always_comb begin
    inst_pl = '{wr: bus.inst_wr, size: bus.inst_size, wstrb: bus.inst_wstrb,
                addr: bus.inst_addr, wdata: bus.inst_wdata};
    data_pl = '{wr: bus.data_wr, size: bus.data_size, wstrb: bus.data_wstrb,
                addr: bus.data_addr, wdata: bus.data_wdata};
    mem_pl  = (grant == GNT_DATA) ? data_pl : inst_pl;
  end

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_wr    = mem_pl.wr;
  assign bus.mem_size  = mem_pl.size;
  assign bus.mem_wstrb = mem_pl.wstrb;
  assign bus.mem_addr  = mem_pl.addr;
  assign bus.mem_wdata = mem_pl.wdata;

  assign bus.inst_addr_ok = bus.mem_addr_ok && mem_req_c && (grant == GNT_INST);
  assign bus.data_addr_ok = bus.mem_addr_ok && mem_req_c && (grant == GNT_DATA);

  // Returns are steered by the oldest outstanding ID; spurious returns pop nothing.
  assign fifo_pop          = resetn && bus.mem_data_ok && !fifo_empty;
  assign bus.inst_data_ok  = fifo_pop && (fifo_head == ID_INST);
  assign bus.data_data_ok  = fifo_pop && (fifo_head == ID_DATA);
  assign bus.inst_rdata    = bus.mem_rdata;
  assign bus.data_rdata    = bus.mem_rdata;

  arb_id_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (handshake),
    .pop    (fifo_pop),
    .din    (grant_id),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Lock holds a stalled grant; any non-stalled cycle re-arbitrates.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid <= 1'b0;
      lock_id    <= ID_INST;
    end else if (mem_req_c && !bus.mem_addr_ok) begin
      lock_valid <= 1'b1;
      lock_id    <= grant_id;
    end else begin
      lock_valid <= 1'b0;
    end
  end

  // Counts data handshakes taken while inst is waiting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!bus.inst_req) begin
      starve_cnt <= '0;
    end else if (handshake && (grant == GNT_INST)) begin
      starve_cnt <= '0;
    end else if (handshake && (grant == GNT_DATA) && !starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arb_err <= 1'b0;
    end else if (bus.mem_data_ok && fifo_empty) begin
      arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios pinned by literal values,
// then random traffic, all checked each cycle against a queue-based model.
module tb_sram_bus_arbiter;
  import sram_bus_arbiter_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic resetn;
  logic arb_err;

  sram_bus_arbiter_if bus();

  sram_bus_arbiter #(
    .OST_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus.slave),
    .arb_err (arb_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: outstanding owners in issue order (1 = data), lock, starve, error.
  bit mq[$];
  bit m_lock_v;
  bit m_lock_id;
  int m_starve;
  bit m_err;

  // Snapshot of DUT outputs from the most recent cycle.
  logic        s_iak, s_dak, s_idok, s_ddok, s_mreq, s_err;
  logic [31:0] s_maddr, s_irdata;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    mq.delete();
    m_lock_v  = 1'b0;
    m_lock_id = 1'b0;
    m_starve  = 0;
    m_err     = 1'b0;
  endfunction

  // One bus cycle: drive at negedge, check combinational outputs, advance model.
  task automatic cyc(input bit ir, input bit dr, input bit ak, input bit dk,
                     input logic [31:0] iaddr, input logic [31:0] rdata);
    int   g;
    bit   full, empty, hs, pop, head;
    logic [70:0] ipl, dpl;
    @(negedge clk);
    bus.inst_req   = ir;
    bus.inst_wr    = 1'($urandom);
    bus.inst_size  = 2'($urandom);
    bus.inst_wstrb = 4'($urandom);
    bus.inst_addr  = iaddr;
    bus.inst_wdata = $urandom;
    bus.data_req   = dr;
    bus.data_wr    = 1'($urandom);
    bus.data_size  = 2'($urandom);
    bus.data_wstrb = 4'($urandom);
    bus.data_addr  = iaddr ^ 32'h4000_0000;
    bus.data_wdata = $urandom;
    bus.mem_addr_ok = ak;
    bus.mem_data_ok = dk;
    bus.mem_rdata   = rdata;
    #1;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    head  = empty ? 1'b0 : mq[0];
    g = 0;
    if (!full) begin
      if (m_lock_v && !m_lock_id && ir)      g = 1;
      else if (m_lock_v && m_lock_id && dr)  g = 2;
      else if (m_starve == LIMIT && ir)      g = 1;
      else if (dr)                           g = 2;
      else if (ir)                           g = 1;
    end
    hs  = (g != 0) && ak;
    pop = dk && !empty;
    ipl = {bus.inst_wr, bus.inst_size, bus.inst_wstrb, bus.inst_addr, bus.inst_wdata};
    dpl = {bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata};

    chk1("mem_req", bus.mem_req, g != 0);
    chk1("inst_addr_ok", bus.inst_addr_ok, hs && g == 1);
    chk1("data_addr_ok", bus.data_addr_ok, hs && g == 2);
    chk1("inst_data_ok", bus.inst_data_ok, pop && !head);
    chk1("data_data_ok", bus.data_data_ok, pop && head);
    chk1("arb_err", arb_err, m_err);
    if (g != 0)
      chkv("mem_payload",
           {bus.mem_wr, bus.mem_size, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata},
           (g == 1) ? ipl : dpl);
    chkv("inst_rdata", 71'(bus.inst_rdata), 71'(rdata));
    chkv("data_rdata", 71'(bus.data_rdata), 71'(rdata));

    s_iak = bus.inst_addr_ok;  s_dak = bus.data_addr_ok;
    s_idok = bus.inst_data_ok; s_ddok = bus.data_data_ok;
    s_mreq = bus.mem_req;      s_err = arb_err;
    s_maddr = bus.mem_addr;    s_irdata = bus.inst_rdata;

    if (dk && empty) m_err = 1'b1;
    if (pop) void'(mq.pop_front());
    if (hs) mq.push_back(g == 2);
    if (hs)            m_lock_v = 1'b0;
    else if (g != 0) begin m_lock_v = 1'b1; m_lock_id = (g == 2); end
    else               m_lock_v = 1'b0;
    if (!ir)                                m_starve = 0;
    else if (hs && g == 1)                  m_starve = 0;
    else if (hs && g == 2 && m_starve < LIMIT) m_starve++;
  endtask

  // Asserts reset mid-cycle with active inputs; outputs must drop at once.
  task automatic do_reset();
    bus.inst_req = 1'b1; bus.data_req = 1'b1;
    bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk1("rst_inst_addr_ok", bus.inst_addr_ok, 1'b0);
    chk1("rst_data_addr_ok", bus.data_addr_ok, 1'b0);
    chk1("rst_inst_data_ok", bus.inst_data_ok, 1'b0);
    chk1("rst_data_data_ok", bus.data_data_ok, 1'b0);
    chk1("rst_arb_err", arb_err, 1'b0);
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
    bus.inst_req = 1'b0; bus.data_req = 1'b0;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0;
  endtask

  initial begin
    string seq;
    bit ir, dr, ak, dk;
    resetn = 1'b1;
    bus.inst_req = 1'b0; bus.inst_wr = 1'b0; bus.inst_size = '0; bus.inst_wstrb = '0;
    bus.inst_addr = '0; bus.inst_wdata = '0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = '0; bus.data_wstrb = '0;
    bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
    do_reset();

    // Single read, inst master.
    cyc(1, 0, 1, 0, 32'h1c00_0000, $urandom);
    chk1("ird_addr_ok", s_iak, 1'b1);
    chk1("ird_no_data_addr_ok", s_dak, 1'b0);
    chkv("ird_addr", 71'(s_maddr), 71'(32'h1c00_0000));
    cyc(0, 0, 0, 0, $urandom, $urandom);
    cyc(0, 0, 0, 1, $urandom, 32'h0280_0000);
    chk1("ird_data_ok", s_idok, 1'b1);
    chk1("ird_no_data_data_ok", s_ddok, 1'b0);
    chkv("ird_rdata", 71'(s_irdata), 71'(32'h0280_0000));

    // Single read, data master.
    do_reset();
    cyc(0, 1, 1, 0, 32'h1c00_0000, $urandom);
    chk1("drd_addr_ok", s_dak, 1'b1);
    chkv("drd_addr", 71'(s_maddr), 71'(32'h5c00_0000));
    cyc(0, 0, 0, 0, $urandom, $urandom);
    cyc(0, 0, 0, 1, $urandom, 32'h0280_0000);
    chk1("drd_data_ok", s_ddok, 1'b1);
    chk1("drd_no_inst_data_ok", s_idok, 1'b0);

    // Both masters always requesting: starvation guard pattern.
    do_reset();
    seq = "";
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 1, i > 0, $urandom, $urandom);
      seq = {seq, s_dak ? "D" : (s_iak ? "I" : "-")};
    end
    n_cmp++;
    if (seq != "DDDDIDDDDI") begin
      n_bad++;
      $display("FAIL starve_pattern: got %s expected DDDDIDDDDI", seq);
    end

    // Lock then withdraw.
    do_reset();
    cyc(1, 0, 0, 0, 32'h1c00_0000, $urandom);
    chkv("lock_c0_addr", 71'(s_maddr), 71'(32'h1c00_0000));
    cyc(1, 1, 0, 0, 32'h1c00_0000, $urandom);
    chkv("lock_c1_addr", 71'(s_maddr), 71'(32'h1c00_0000));
    cyc(0, 1, 1, 0, 32'h1c00_0000, $urandom);
    chk1("lock_c2_data_ok", s_dak, 1'b1);
    chkv("lock_c2_addr", 71'(s_maddr), 71'(32'h5c00_0000));

    // FIFO full and in-order return routing.
    do_reset();
    cyc(1, 0, 1, 0, $urandom, $urandom);
    cyc(0, 1, 1, 0, $urandom, $urandom);
    cyc(1, 0, 1, 0, $urandom, $urandom);
    cyc(0, 1, 1, 0, $urandom, $urandom);
    cyc(1, 1, 1, 0, $urandom, $urandom);
    chk1("full_blocks", s_mreq, 1'b0);
    cyc(1, 1, 1, 1, $urandom, $urandom);
    chk1("full_blocks_on_pop", s_mreq, 1'b0);
    chk1("full_ret0_inst", s_idok, 1'b1);
    cyc(1, 1, 1, 0, $urandom, $urandom);
    chk1("full_resume", s_dak, 1'b1);
    cyc(0, 0, 0, 1, $urandom, $urandom);
    chk1("full_ret1_data", s_ddok, 1'b1);
    cyc(0, 0, 0, 1, $urandom, $urandom);
    chk1("full_ret2_inst", s_idok, 1'b1);
    cyc(0, 0, 0, 1, $urandom, $urandom);
    chk1("full_ret3_data", s_ddok, 1'b1);

    // Spurious return.
    do_reset();
    cyc(0, 0, 0, 1, $urandom, $urandom);
    chk1("spur_no_idok", s_idok, 1'b0);
    chk1("spur_no_ddok", s_ddok, 1'b0);
    cyc(0, 0, 0, 0, $urandom, $urandom);
    chk1("spur_err_set", s_err, 1'b1);
    cyc(1, 0, 1, 0, $urandom, $urandom);
    chk1("spur_err_sticky", s_err, 1'b1);

    // Async reset with requests outstanding, then a stale return.
    do_reset();
    cyc(1, 0, 1, 0, $urandom, $urandom);
    cyc(0, 1, 1, 0, $urandom, $urandom);
    do_reset();
    cyc(0, 0, 0, 1, $urandom, $urandom);
    chk1("stale_no_idok", s_idok, 1'b0);
    chk1("stale_no_ddok", s_ddok, 1'b0);
    cyc(0, 0, 0, 0, $urandom, $urandom);
    chk1("stale_err", s_err, 1'b1);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      ir = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 3) != 0);
      ak = ($urandom_range(0, 2) != 0);
      if (mq.size() > 0) dk = 1'($urandom);
      else               dk = ($urandom_range(0, 299) == 0);
      cyc(ir, dr, ak, dk, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
